// File: rtl/memory_stage.sv
// memory_stage: pipeline MEM stage with an internal word-organised data RAM.
// Performs byte/half/word loads and stores with WAIT_CYCLES wait states,
// sign/zero-extends loads and registers results into the MEM/WB register.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (trap on misaligned accesses;
// when undefined, low address bits are masked to natural alignment).
//
// Ports:
//   clk, reset (sync, active-low)
//   ex_*            EX/MEM register inputs (valid, class, types, address,
//                   store data, ALU result, rd, reg_write)
//   mem_busy        access in flight; upstream holds EX/MEM and PC
//   mem_wb_*        registered MEM/WB entry (valid, rd, reg_write, result,
//                   is_load)
//   mem_trap        one-cycle misaligned-access pulse
//   mem_trap_addr   faulting address, held until the next trap
module memory_stage #(
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_load_type,
    input  logic [2:0]  ex_store_type,
    input  logic [31:0] ex_ram_address,
    input  logic [31:0] ex_store_data,
    input  logic [31:0] ex_result,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    output logic        mem_busy,
    output logic        mem_wb_valid,
    output logic [4:0]  mem_wb_rd,
    output logic        mem_wb_reg_write,
    output logic [31:0] mem_wb_result,
    output logic        mem_wb_is_load,
    output logic        mem_trap,
    output logic [31:0] mem_trap_addr
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned LAW  = AW + 2;
    localparam logic [2:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    localparam logic [2:0] T_B  = 3'b000;
    localparam logic [2:0] T_H  = 3'b001;
    localparam logic [2:0] T_W  = 3'b010;
    localparam logic [2:0] T_BU = 3'b100;
    localparam logic [2:0] T_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [2:0]     r_cnt;
    logic [2:0]     w_cnt_next;

    // Latched memory operation
    logic [LAW-1:0] r_addr;
    logic [31:0]    r_data;
    logic [2:0]     r_type;
    logic           r_is_load;
    logic [4:0]     r_rd;
    logic           r_reg_write;

    logic [31:0]    r_ram [DEPTH];

    logic           w_is_mem;
    logic           w_word_op;
    logic           w_half_op;
    logic           w_misaligned;
    logic [31:0]    w_addr_aligned;
    logic           w_latch;
    logic           w_trap;

    logic           w_wb_we;
    logic           w_wb_valid;
    logic [4:0]     w_wb_rd;
    logic           w_wb_reg_write;
    logic [31:0]    w_wb_result;
    logic           w_wb_is_load;

    logic           w_ram_we;
    logic [3:0]     w_be;
    logic [31:0]    w_wdata;
    logic [31:0]    w_word;
    logic [7:0]     w_byte;
    logic [15:0]    w_half;
    logic [31:0]    w_load_data;
    logic [AW-1:0]  w_idx;

    logic           w_unused;
    assign w_unused = &{1'b0, ex_ram_address[31:LAW]};

    assign mem_busy = (r_state != S_IDLE);
    assign w_idx    = r_addr[LAW-1:2];

    // Access size classification of the incoming instruction
    always_comb begin
        w_is_mem  = ex_is_load | ex_is_store;
        w_word_op = 1'b0;
        w_half_op = 1'b0;
        if (ex_is_load) begin
            w_word_op = (ex_load_type == T_W);
            w_half_op = (ex_load_type == T_H) || (ex_load_type == T_HU);
        end else if (ex_is_store) begin
            w_word_op = (ex_store_type == T_W);
            w_half_op = (ex_store_type == T_H);
        end
        w_addr_aligned = ex_ram_address;
        if (w_word_op) begin
            w_addr_aligned[1:0] = 2'b00;
        end
        if (w_half_op) begin
            w_addr_aligned[0] = 1'b0;
        end
`ifdef MEM_MISALIGN_TRAP_EN
        w_misaligned = (w_word_op && (ex_ram_address[1:0] != 2'b00)) ||
                       (w_half_op && ex_ram_address[0]);
`else
        w_misaligned = 1'b0;
`endif
    end

    // Load extraction and store lane generation for the latched operation
    always_comb begin
        w_word = r_ram[w_idx];
        w_byte = w_word[{r_addr[1:0], 3'b000} +: 8];
        w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];
        case (r_type)
            T_B:     w_load_data = {{24{w_byte[7]}}, w_byte};
            T_H:     w_load_data = {{16{w_half[15]}}, w_half};
            T_W:     w_load_data = w_word;
            T_BU:    w_load_data = {24'd0, w_byte};
            T_HU:    w_load_data = {16'd0, w_half};
            default: w_load_data = 32'd0;
        endcase

        w_be    = 4'b0000;
        w_wdata = r_data;
        case (r_type)
            T_B: begin
                w_be    = 4'(4'b0001 << r_addr[1:0]);
                w_wdata = {4{r_data[7:0]}};
            end
            T_H: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_data[15:0]}};
            end
            T_W: begin
                w_be    = 4'b1111;
                w_wdata = r_data;
            end
            default: w_be = 4'b0000;
        endcase
    end

    // Next-state and MEM/WB next-value logic
    always_comb begin
        w_next_state   = r_state;
        w_cnt_next     = r_cnt;
        w_latch        = 1'b0;
        w_trap         = 1'b0;
        w_ram_we       = 1'b0;
        w_wb_we        = 1'b0;
        w_wb_valid     = 1'b0;
        w_wb_rd        = mem_wb_rd;
        w_wb_reg_write = 1'b0;
        w_wb_result    = mem_wb_result;
        w_wb_is_load   = mem_wb_is_load;

        case (r_state)
            S_IDLE: begin
                if (ex_valid) begin
                    if (w_is_mem) begin
                        if (w_misaligned) begin
                            w_trap = 1'b1;
                        end else begin
                            w_latch      = 1'b1;
                            w_cnt_next   = CNT_INIT;
                            w_next_state = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                        end
                    end else begin
                        w_wb_we        = 1'b1;
                        w_wb_valid     = 1'b1;
                        w_wb_rd        = ex_rd;
                        w_wb_reg_write = ex_reg_write && (ex_rd != 5'd0);
                        w_wb_result    = ex_result;
                        w_wb_is_load   = 1'b0;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_next_state = S_ACCESS;
                end else begin
                    w_cnt_next = r_cnt - 3'd1;
                end
            end
            S_ACCESS: begin
                w_next_state = S_IDLE;
                w_wb_we      = 1'b1;
                w_wb_valid   = 1'b1;
                w_wb_rd      = r_rd;
                if (r_is_load) begin
                    w_wb_reg_write = r_reg_write && (r_rd != 5'd0);
                    w_wb_result    = w_load_data;
                    w_wb_is_load   = 1'b1;
                end else begin
                    w_ram_we       = 1'b1;
                    w_wb_reg_write = 1'b0;
                    w_wb_result    = 32'd0;
                    w_wb_is_load   = 1'b0;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State, operation latch and MEM/WB registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state          <= S_IDLE;
            r_cnt            <= 3'd0;
            r_addr           <= '0;
            r_data           <= 32'd0;
            r_type           <= 3'd0;
            r_is_load        <= 1'b0;
            r_rd             <= 5'd0;
            r_reg_write      <= 1'b0;
            mem_wb_valid     <= 1'b0;
            mem_wb_rd        <= 5'd0;
            mem_wb_reg_write <= 1'b0;
            mem_wb_result    <= 32'd0;
            mem_wb_is_load   <= 1'b0;
        end else begin
            r_state          <= w_next_state;
            r_cnt            <= w_cnt_next;
            mem_wb_valid     <= w_wb_valid;
            mem_wb_reg_write <= w_wb_reg_write;
            if (w_wb_we) begin
                mem_wb_rd      <= w_wb_rd;
                mem_wb_result  <= w_wb_result;
                mem_wb_is_load <= w_wb_is_load;
            end
            if (w_latch) begin
                r_addr      <= w_addr_aligned[LAW-1:0];
                r_data      <= ex_store_data;
                r_type      <= ex_is_load ? ex_load_type : ex_store_type;
                r_is_load   <= ex_is_load;
                r_rd        <= ex_rd;
                r_reg_write <= ex_reg_write;
            end
        end
    end

    // Data RAM byte-lane writes; contents are not reset
    always_ff @(posedge clk) begin
        if (reset && w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_ram[w_idx][i*8 +: 8] <= w_wdata[i*8 +: 8];
                end
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned-access trap pulse and held faulting address
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_trap      <= 1'b0;
            mem_trap_addr <= 32'd0;
        end else begin
            mem_trap <= w_trap;
            if (w_trap) begin
                mem_trap_addr <= ex_ram_address;
            end
        end
    end
`else
    logic w_unused_trap;
    assign w_unused_trap = w_trap;
    assign mem_trap      = 1'b0;
    assign mem_trap_addr = 32'd0;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed stimulus pushes expected
// MEM/WB entries into a queue, a monitor thread pops and compares them.
module tb_memory_stage;

    localparam int unsigned DEPTH = 512;
    localparam int unsigned WC    = 1;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [2:0]  ex_load_type;
    logic [2:0]  ex_store_type;
    logic [31:0] ex_ram_address;
    logic [31:0] ex_store_data;
    logic [31:0] ex_result;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        mem_busy;
    logic        mem_wb_valid;
    logic [4:0]  mem_wb_rd;
    logic        mem_wb_reg_write;
    logic [31:0] mem_wb_result;
    logic        mem_wb_is_load;
    logic        mem_trap;
    logic [31:0] mem_trap_addr;

    memory_stage #(.DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clk              (clk),
        .reset            (reset),
        .ex_valid         (ex_valid),
        .ex_is_load       (ex_is_load),
        .ex_is_store      (ex_is_store),
        .ex_load_type     (ex_load_type),
        .ex_store_type    (ex_store_type),
        .ex_ram_address   (ex_ram_address),
        .ex_store_data    (ex_store_data),
        .ex_result        (ex_result),
        .ex_rd            (ex_rd),
        .ex_reg_write     (ex_reg_write),
        .mem_busy         (mem_busy),
        .mem_wb_valid     (mem_wb_valid),
        .mem_wb_rd        (mem_wb_rd),
        .mem_wb_reg_write (mem_wb_reg_write),
        .mem_wb_result    (mem_wb_result),
        .mem_wb_is_load   (mem_wb_is_load),
        .mem_trap         (mem_trap),
        .mem_trap_addr    (mem_trap_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] res;
        logic        is_load;
        logic        chk_res;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec;
    int   n_err;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_valid       = 1'b0;
        ex_is_load     = 1'b0;
        ex_is_store    = 1'b0;
        ex_load_type   = 3'd0;
        ex_store_type  = 3'd0;
        ex_ram_address = 32'd0;
        ex_store_data  = 32'd0;
        ex_result      = 32'd0;
        ex_rd          = 5'd0;
        ex_reg_write   = 1'b0;
    endtask

    function automatic logic [79:0] all_outputs();
        return 80'({mem_busy, mem_wb_valid, mem_wb_rd, mem_wb_reg_write,
                    mem_wb_result, mem_wb_is_load, mem_trap, mem_trap_addr});
    endfunction

    task automatic present(input logic ld, input logic [2:0] typ, input logic [31:0] addr,
                           input logic [31:0] data, input logic [4:0] rd);
        @(negedge clk);
        ex_valid       = 1'b1;
        ex_is_load     = ld;
        ex_is_store    = ~ld;
        ex_load_type   = typ;
        ex_store_type  = typ;
        ex_ram_address = addr;
        ex_store_data  = data;
        ex_rd          = rd;
        ex_reg_write   = 1'b1;
    endtask

    // Issue a load or store, queue its expected MEM/WB entry, count busy cycles
    task automatic mem_op(input string name, input logic ld, input logic [2:0] typ,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] rd, input logic [31:0] exp_res);
        exp_t e;
        int   n;
        bit   done;
        present(ld, typ, addr, data, rd);
        e.rd      = rd;
        e.rw      = ld && (rd != 5'd0);
        e.res     = exp_res;
        e.is_load = ld;
        e.chk_res = ld;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        idle_inputs();
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!mem_busy) done = 1'b1;
            else n++;
        end
        check({name, "_busy"}, 80'(n), 80'(WC + 1));
    endtask

    task automatic alu_op(input string name, input logic [4:0] rd, input logic [31:0] res,
                          input logic rw);
        exp_t e;
        @(negedge clk);
        ex_valid     = 1'b1;
        ex_is_load   = 1'b0;
        ex_is_store  = 1'b0;
        ex_result    = res;
        ex_rd        = rd;
        ex_reg_write = rw;
        e.rd      = rd;
        e.rw      = rw && (rd != 5'd0);
        e.res     = res;
        e.is_load = 1'b0;
        e.chk_res = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        idle_inputs();
        check({name, "_busy"}, 80'(mem_busy), 80'(0));
        @(negedge clk);
        check({name, "_busy_next"}, 80'(mem_busy), 80'(0));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        idle_inputs();

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (reset && mem_wb_valid) begin
                        if (sb_q.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL wb_unexpected: got valid entry rd=%0d result=%h, required no entry",
                                     mem_wb_rd, mem_wb_result);
                        end else begin
                            e = sb_q.pop_front();
                            check("wb_reg_write", 80'(mem_wb_reg_write), 80'(e.rw));
                            check("wb_is_load", 80'(mem_wb_is_load), 80'(e.is_load));
                            if (e.chk_res) begin
                                check("wb_rd", 80'(mem_wb_rd), 80'(e.rd));
                                check("wb_result", 80'(mem_wb_result), 80'(e.res));
                            end
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outputs(), 80'(0));
        reset = 1'b1;

        // Word store/load round trip
        mem_op("sw_10", 1'b0, 3'b010, 32'h10, 32'hDEADBEEF, 5'd1, 32'h0);
        mem_op("lw_10", 1'b1, 3'b010, 32'h10, 32'h0, 5'd7, 32'hDEADBEEF);

        // Byte and half accesses with sign/zero extension
        mem_op("sw_20", 1'b0, 3'b010, 32'h20, 32'h0, 5'd0, 32'h0);
        mem_op("sb_21", 1'b0, 3'b000, 32'h21, 32'h00000080, 5'd0, 32'h0);
        mem_op("lb_21", 1'b1, 3'b000, 32'h21, 32'h0, 5'd3, 32'hFFFFFF80);
        mem_op("lbu_21", 1'b1, 3'b100, 32'h21, 32'h0, 5'd4, 32'h00000080);
        mem_op("sh_22", 1'b0, 3'b001, 32'h22, 32'h00008001, 5'd0, 32'h0);
        mem_op("lh_22", 1'b1, 3'b001, 32'h22, 32'h0, 5'd6, 32'hFFFF8001);
        mem_op("lhu_22", 1'b1, 3'b101, 32'h22, 32'h0, 5'd8, 32'h00008001);
        mem_op("lw_20", 1'b1, 3'b010, 32'h20, 32'h0, 5'd10, 32'h80018000);

        // Undefined load type returns zero
        mem_op("ld_undef", 1'b1, 3'b011, 32'h10, 32'h0, 5'd9, 32'h0);

        // Misaligned word load
        mem_op("sw_04", 1'b0, 3'b010, 32'h04, 32'h12345678, 5'd0, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
        present(1'b1, 3'b010, 32'h06, 32'h0, 5'd11);
        @(posedge clk);
        #1;
        idle_inputs();
        check("trap_pulse", 80'(mem_trap), 80'(1));
        check("trap_addr", 80'(mem_trap_addr), 80'(32'h06));
        check("trap_busy", 80'(mem_busy), 80'(0));
        @(posedge clk);
        #1;
        check("trap_clear", 80'(mem_trap), 80'(0));
        check("trap_addr_hold", 80'(mem_trap_addr), 80'(32'h06));
`else
        mem_op("lw_06", 1'b1, 3'b010, 32'h06, 32'h0, 5'd11, 32'h12345678);
        mem_op("lh_23", 1'b1, 3'b001, 32'h23, 32'h0, 5'd12, 32'hFFFF8001);
        check("trap_tied", 80'({mem_trap, mem_trap_addr}), 80'(0));
`endif

        // ALU results bypass the RAM
        alu_op("alu_rd5", 5'd5, 32'd42, 1'b1);
        alu_op("alu_rd0", 5'd0, 32'd42, 1'b1);

        // Address wrap-around modulo DEPTH*4
        mem_op("sw_wrap", 1'b0, 3'b010, 32'(4 * DEPTH + 8), 32'hCAFEF00D, 5'd0, 32'h0);
        mem_op("lw_wrap", 1'b1, 3'b010, 32'h08, 32'h0, 5'd13, 32'hCAFEF00D);

        // Reset mid-WAIT abandons an in-flight store
        mem_op("sw_40", 1'b0, 3'b010, 32'h40, 32'h11111111, 5'd0, 32'h0);
        present(1'b0, 3'b010, 32'h40, 32'h22222222, 5'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        check("wait_busy", 80'(mem_busy), 80'(1));
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midwait_reset_outputs", all_outputs(), 80'(0));
        reset = 1'b1;
        mem_op("lw_40", 1'b1, 3'b010, 32'h40, 32'h0, 5'd14, 32'h11111111);

        repeat (3) @(negedge clk);
        check("sb_empty", 80'(sb_q.size()), 80'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage, directly downstream of the execute stage. Takes the EX/MEM result, RAM address, store data and load/store type, and performs byte/half/word accesses on an internal word-organised data RAM with a configurable number of wait states. Loads are sign- or zero-extended. Results, together with rd and write-enable, are registered into the MEM/WB register feeding writeback and EX forwarding. A busy flag stalls upstream stages while an access is in flight.

## Interface
- DEPTH, 512: data RAM size in 32-bit words; power of two.
- WAIT_CYCLES, 1: extra wait states per load/store, 0..7.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; low at a rising edge resets the stage.
- ex_valid  in  1  EX/MEM holds a valid instruction.
- ex_is_load / ex_is_store  in  1 each  instruction class; never both high.
- ex_load_type  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- ex_store_type  in  3  000 SB, 001 SH, 010 SW.
- ex_ram_address  in  32  byte address.
- ex_store_data  in  32  forwarded rs2 value.
- ex_result  in  32  ALU/jump result for non-memory instructions.
- ex_rd  in  5  destination register.
- ex_reg_write  in  1  destination write enable.
- mem_busy  out  1  access in flight; upstream must hold EX/MEM and the PC.
- mem_wb_valid  out  1  MEM/WB entry valid.
- mem_wb_rd  out  5  registered rd.
- mem_wb_reg_write  out  1  registered write enable; forced 0 when rd=0.
- mem_wb_result  out  32  registered load data or ex_result.
- mem_wb_is_load  out  1  entry came from a load.
- mem_trap  out  1  one-cycle misaligned-access pulse.
- mem_trap_addr  out  32  faulting address, held until the next trap.

## Operation
- FSM states: IDLE, WAIT, ACCESS.
- In IDLE with ex_valid:
  - Non-memory instruction: ex_result, rd and reg_write go to MEM/WB at this edge. State stays IDLE.
  - Load or store: address, data, type and rd are latched. State moves to WAIT if WAIT_CYCLES>0, else to ACCESS. The counter loads WAIT_CYCLES-1.
- In WAIT: decrement the counter each cycle; move to ACCESS when it reaches 0.
- In ACCESS: perform the RAM operation and go to IDLE. A load writes MEM/WB with is_load=1. A store writes MEM/WB with valid=1 and reg_write=0.
- EX inputs are sampled only in IDLE and ignored in WAIT and ACCESS.
- mem_busy = (state != IDLE), decoded directly from the state register.
- Word index = addr[log2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH*4.
- Stores use byte-lane writes with addr[1:0] selecting the lane:
  - SB writes the lane data[7:0].
  - SH writes lanes {addr[1],0}/{addr[1],1}.
  - SW writes all four lanes.
- Loads:
  - Select the byte or half using addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - An undefined load_type returns 0.
- Misaligned access (LW/SW with addr[1:0]≠0, or LH/LHU/SH with addr[0]≠0):
  - No RAM access and no FSM entry.
  - mem_trap=1 for one cycle, mem_trap_addr latched.
  - mem_wb_valid=0 at that edge.
- With ex_valid=0 in IDLE: mem_wb_valid=0 and mem_wb_reg_write=0.
- Reset: FSM to IDLE; all outputs 0, mem_trap_addr included. An in-flight store not yet in ACCESS is abandoned and the RAM is untouched. RAM contents are not reset.

## Timing
- Non-memory instruction: MEM/WB valid 1 cycle after acceptance.
- Load/store: MEM/WB updated WAIT_CYCLES+1 edges after the acceptance edge. mem_busy is high for exactly WAIT_CYCLES+1 cycles, starting the cycle after acceptance.
- Back-to-back memory operations: the next one is accepted on the edge where state returns to IDLE. Throughput is one access per WAIT_CYCLES+2 cycles.
- RAM read and write are synchronous within the ACCESS cycle. A load immediately following a store to the same word returns the stored data.
- reset low during WAIT or ACCESS: the next edge is IDLE with mem_busy=0.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: misaligned accesses trap as described above.
- MEM_MISALIGN_TRAP_EN undefined:
  - Address low bits are masked to natural alignment (addr[1:0] cleared for words, addr[0] for halves) and the access proceeds normally.
  - mem_trap is tied 0; mem_trap_addr is tied 0.

## Test plan
- Reset held low 2 cycles mid-WAIT: all outputs 0, state IDLE, a later LW of the targeted word returns its pre-store value.
- WAIT_CYCLES=1, SW 0xDEADBEEF to 0x10, then LW 0x10: mem_busy high 2 cycles each, mem_wb_result=0xDEADBEEF, rd as issued.
- SB 0x80 to 0x21, then LB 0x21 gives 0xFFFFFF80, LBU 0x21 gives 0x00000080. SH 0x8001 to 0x22, then LH 0x22 gives 0xFFFF8001.
- LW 0x06 with the macro defined: mem_trap pulse, mem_trap_addr=0x06, no WB write. With the macro undefined: the value at 0x04 is returned.
- ALU op with rd=5, result 42, in IDLE: mem_wb_result=42 next cycle, mem_busy never asserted. The same op with rd=0 gives mem_wb_reg_write=0.
- Address 4*DEPTH+8: aliases to word 2 (wrap-around verified by a store/load pair).
